// File: rtl/reflet_uart_boot_loader_pkg.sv
// Shared constants for the UART boot loader: sync byte and state encodings
// for both the loader FSM and the reusable RX core.
package reflet_uart_boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h5A;

  localparam logic [2:0] WAIT_SYNC = 3'd0;
  localparam logic [2:0] GET_LEN   = 3'd1;
  localparam logic [2:0] GET_DATA  = 3'd2;
  localparam logic [2:0] GET_SUM   = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;
  localparam logic [2:0] FAIL      = 3'd5;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/reflet_uart_boot_loader_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, bit-centre sampling, one-cycle
// byte_valid / frame_err strobes. Shared with the UART peripheral.
module reflet_uart_rx_core
  import reflet_uart_boot_loader_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int BIT_PERIOD = clk_freq / baud_rate;
  localparam int HALF       = BIT_PERIOD / 2;
  localparam int CNT_W      = $clog2(BIT_PERIOD);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // A short low glitch is rejected by re-checking the start bit at half period.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_W'(BIT_PERIOD - 1)) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_W'(BIT_PERIOD - 1)) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              rx_byte    <= shift;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reflet_uart_boot_loader.sv
// Serial boot loader: holds the CPU in reset, loads a framed image
// (sync, length, data, checksum) into instruction RAM, then releases it.
module reflet_uart_boot_loader
  import reflet_uart_boot_loader_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 100000,
  parameter int addr_size = 7,
  parameter int load_size = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 boot_req,
  output logic [addr_size-1:0] mem_addr,
  output logic [7:0]           mem_data,
  output logic                 mem_write_en,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error
);

  logic [7:0]           rx_byte;
  logic                 byte_valid;
  logic                 frame_err;
  logic [2:0]           state;
  logic [7:0]           count;
  logic [addr_size-1:0] addr;
  logic [7:0]           checksum;
  logic [7:0]           sum_next;

  reflet_uart_rx_core #(
    .clk_freq (clk_freq),
    .baud_rate(baud_rate)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_comb begin
    sum_next = checksum + rx_byte;
  end

  // boot_req overrides any byte arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_SYNC;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= 8'h00;
      count        <= 8'h00;
      addr         <= '0;
      checksum     <= 8'h00;
    end else begin
      mem_write_en <= 1'b0;
      if (boot_req) begin
        state    <= WAIT_SYNC;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
      end else begin
        case (state)
          WAIT_SYNC: begin
            if (byte_valid && rx_byte == SYNC_BYTE) begin
              state    <= GET_LEN;
              error    <= 1'b0;
              checksum <= 8'h00;
            end
          end
          GET_LEN: begin
            if (frame_err) begin
              state <= FAIL;
              error <= 1'b1;
            end else if (byte_valid) begin
              if (rx_byte == 8'h00 || rx_byte > 8'(load_size)) begin
                state <= FAIL;
                error <= 1'b1;
              end else begin
                count <= rx_byte;
                addr  <= '0;
                state <= GET_DATA;
              end
            end
          end
          GET_DATA: begin
            if (frame_err) begin
              state <= FAIL;
              error <= 1'b1;
            end else if (byte_valid) begin
              mem_data     <= rx_byte;
              mem_addr     <= addr;
              mem_write_en <= 1'b1;
              checksum     <= sum_next;
              addr         <= addr + 1'b1;
              count        <= count - 8'd1;
              if (count == 8'd1) state <= GET_SUM;
            end
          end
          GET_SUM: begin
            if (frame_err) begin
              state <= FAIL;
              error <= 1'b1;
            end else if (byte_valid) begin
              if (sum_next == 8'h00) begin
                state    <= DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state <= FAIL;
                error <= 1'b1;
              end
            end
          end
          DONE: begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
          FAIL: begin
            state <= WAIT_SYNC;
          end
          default: state <= WAIT_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reflet_uart_boot_loader.sv
// Directed bench for the UART boot loader; expected memory writes go into a
// scoreboard queue as bytes are sent and are popped by a write monitor.
module tb_reflet_uart_boot_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       boot_req;
  logic [6:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_write_en;
  logic       cpu_hold;
  logic       done;
  logic       error;

  int          checks = 0;
  int          errors = 0;
  logic [14:0] sb[$];
  logic [14:0] exp_wr;
  logic        prev_we = 1'b0;

  reflet_uart_boot_loader #(
    .clk_freq (1000000),
    .baud_rate(100000),
    .addr_size(7),
    .load_size(128)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .boot_req    (boot_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_write_en(mem_write_en),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_write_en === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_write observed addr=%0h data=%0h expected no write",
               mem_addr, mem_data);
      end
      if (sb.size() > 0) begin
        exp_wr = sb.pop_front();
        checks++;
        assert ({mem_addr, mem_data} === exp_wr) else begin
          errors++;
          $error("[TB] FAIL write observed addr=%0h data=%0h expected addr=%0h data=%0h",
                 mem_addr, mem_data, exp_wr[14:8], exp_wr[7:0]);
        end
      end
      checks++;
      assert (prev_we === 1'b0) else begin
        errors++;
        $error("[TB] FAIL back_to_back observed prev_we=%b expected 0", prev_we);
      end
    end
    prev_we = mem_write_en;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bitWait();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    rx = 1'b0;
    bitWait();
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      bitWait();
    end
    rx = stop_bit;
    bitWait();
    if (!stop_bit) begin
      rx = 1'b1;
      bitWait();
    end
  endtask

  task automatic pulseBoot();
    @(posedge clk);
    #1 boot_req = 1'b1;
    @(posedge clk);
    #1 boot_req = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    rx       = 1'b1;
    boot_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_data", 32'(mem_data), 32'h0);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_hold", 32'(cpu_hold), 32'h1);
    checkOutput("idle_done", 32'(done), 32'h0);
    checkOutput("idle_error", 32'(error), 32'h0);

    $display("[TB] good load of three bytes");
    @(posedge clk); #1;
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h03, 1'b1);
    sb.push_back({7'd0, 8'h11}); applyStimulus(8'h11, 1'b1);
    sb.push_back({7'd1, 8'h22}); applyStimulus(8'h22, 1'b1);
    sb.push_back({7'd2, 8'h33}); applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h9A, 1'b1);
    settle();
    checkOutput("good_done", 32'(done), 32'h1);
    checkOutput("good_hold", 32'(cpu_hold), 32'h0);
    checkOutput("good_error", 32'(error), 32'h0);
    checkOutput("good_sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] boot_req restart and single-byte image");
    pulseBoot();
    @(negedge clk);
    checkOutput("boot_hold", 32'(cpu_hold), 32'h1);
    checkOutput("boot_done", 32'(done), 32'h0);
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h01, 1'b1);
    sb.push_back({7'd0, 8'hFF}); applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h01, 1'b1);
    settle();
    checkOutput("one_done", 32'(done), 32'h1);
    checkOutput("one_sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] bad checksum then recovery");
    pulseBoot();
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h03, 1'b1);
    sb.push_back({7'd0, 8'h11}); applyStimulus(8'h11, 1'b1);
    sb.push_back({7'd1, 8'h22}); applyStimulus(8'h22, 1'b1);
    sb.push_back({7'd2, 8'h33}); applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h9B, 1'b1);
    settle();
    checkOutput("badsum_error", 32'(error), 32'h1);
    checkOutput("badsum_done", 32'(done), 32'h0);
    checkOutput("badsum_hold", 32'(cpu_hold), 32'h1);
    checkOutput("badsum_sb_empty", 32'(sb.size()), 32'h0);
    applyStimulus(8'h5A, 1'b1);
    settle();
    checkOutput("sync_clears_error", 32'(error), 32'h0);
    applyStimulus(8'h03, 1'b1);
    sb.push_back({7'd0, 8'h11}); applyStimulus(8'h11, 1'b1);
    sb.push_back({7'd1, 8'h22}); applyStimulus(8'h22, 1'b1);
    sb.push_back({7'd2, 8'h33}); applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h9A, 1'b1);
    settle();
    checkOutput("recover_done", 32'(done), 32'h1);
    checkOutput("recover_error", 32'(error), 32'h0);

    $display("[TB] oversize and zero length");
    pulseBoot();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h81, 1'b1);
    settle();
    checkOutput("len81_error", 32'(error), 32'h1);
    checkOutput("len81_hold", 32'(cpu_hold), 32'h1);
    pulseBoot();
    @(negedge clk);
    checkOutput("boot_clears_error", 32'(error), 32'h0);
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h00, 1'b1);
    settle();
    checkOutput("len0_error", 32'(error), 32'h1);
    checkOutput("len_sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] glitch rejection and framing error");
    applyStimulus(8'h5A, 1'b1);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    bitWait();
    bitWait();
    applyStimulus(8'h02, 1'b1);
    sb.push_back({7'd0, 8'h10}); applyStimulus(8'h10, 1'b1);
    applyStimulus(8'h20, 1'b0);
    settle();
    checkOutput("frame_error", 32'(error), 32'h1);
    checkOutput("frame_done", 32'(done), 32'h0);
    checkOutput("frame_hold", 32'(cpu_hold), 32'h1);
    checkOutput("frame_sb_empty", 32'(sb.size()), 32'h0);

    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reflet_uart_boot_loader.md
Name: reflet_uart_boot_loader

Overview:
- Serial program loader sitting upstream of the 8-bit controller's instruction memory.
- Holds the CPU in reset, receives a framed program image over a UART RX line and writes it byte-by-byte into instruction RAM through that memory's write port.
- Releases the CPU once the image's checksum passes.
- Replaces hand-initialised instruction RAM for bring-up on hardware.

Parameters:
- clk_freq, 1000000, system clock frequency in Hz.
- baud_rate, 100000, UART bit rate; bit period = clk_freq/baud_rate clocks (integer, ≥4).
- addr_size, 7, width of the instruction memory address.
- load_size, 128, maximum image length in bytes (≤ 2^addr_size, ≤ 255).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  UART receive line, idle high, 8N1, asynchronous to clk.
- boot_req  input  1  one-cycle pulse; restarts a load session.
- mem_addr  output  addr_size  instruction memory write address.
- mem_data  output  8  instruction memory write data.
- mem_write_en  output  1  one-cycle write strobe.
- cpu_hold  output  1  1 = keep CPU in reset.
- done  output  1  image loaded and verified.
- error  output  1  last session failed: bad length, framing error or checksum mismatch.

Behaviour:
- Reset values: cpu_hold=1, done=0, error=0, mem_write_en=0, mem_addr=0, mem_data=0. FSM goes to WAIT_SYNC and the RX core returns to idle.
- RX core:
  - rx passes through a 2-flop synchroniser.
  - A falling edge starts the bit-period counter. Start bit is re-checked at half period; if it is high, the frame is dropped silently.
  - Data bits are sampled at bit centres, LSB first. Stop bit is sampled at centre.
  - Produces byte_valid (1 cycle) and frame_err (1 cycle, stop bit = 0).
- FSM states and transitions:
  - WAIT_SYNC: wait for byte 0x5A. Other bytes and frame_err are ignored. On 0x5A go to GET_LEN, clear error and checksum.
  - GET_LEN: byte N is captured. If N=0 or N>load_size, go to FAIL. Otherwise set count=N, addr=0 and go to GET_DATA.
  - GET_DATA: each received byte sets mem_data=byte and mem_addr=addr, and mem_write_en=1 for exactly the next cycle. It is also added to the checksum (mod 256), addr increments and count decrements. When count reaches 0, go to GET_SUM.
  - GET_SUM: received byte C. If (checksum+C) mod 256 == 0, go to DONE. Otherwise go to FAIL.
  - DONE: done=1, cpu_hold=0. All RX bytes are ignored.
  - FAIL: error=1 and cpu_hold stays 1. Return to WAIT_SYNC on the next cycle; error persists until the next 0x5A or reset.
- frame_err in GET_LEN, GET_DATA or GET_SUM goes to FAIL. Memory bytes already written are not rolled back.
- Write latency: mem_write_en is asserted the cycle after byte_valid. Writes are never issued back-to-back, and the address never wraps (N ≤ load_size).
- boot_req in any state: cpu_hold=1, done=0, error=0, FSM goes to WAIT_SYNC. A byte in flight in the RX core is allowed to complete and is treated as a WAIT_SYNC byte.
- reset and boot_req in the same cycle: reset wins (identical result).
- byte_valid in the same cycle as boot_req: boot_req wins and the byte is discarded.

Decomposition:
- Shared package constants: SYNC_BYTE=8'h5A; FSM state encoding (WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM, DONE, FAIL).
- One natural sub-module: reflet_uart_rx_core. It contains the synchroniser, bit timer and shift register, and outputs byte, byte_valid and frame_err. It is reusable by the UART peripheral.

Test Plan:
- Reset, rx idle high, 1000 cycles -> cpu_hold=1, done=0, error=0, mem_write_en never asserted.
- Send 0x5A, 0x03, 0x11, 0x22, 0x33, 0x9A -> writes (0,0x11), (1,0x22), (2,0x33), each one cycle after its stop-bit centre. Then done=1, cpu_hold=0.
- Same as previous but checksum 0x9B -> three writes occur, error=1, done=0, cpu_hold=1. Then send a valid session -> error clears on 0x5A and done=1.
- Send 0x00 then 0x5A, length 0x81 (>128) -> 0x00 ignored, error=1 after length byte, no writes.
- After a good load (done=1), pulse boot_req -> cpu_hold=1, done=0 the next cycle. Then send 0x5A, 0x01, 0xFF, 0x01 -> write (0,0xFF), done=1.
- During a data byte of a session, hold rx low through the stop bit -> frame_err, error=1, no write for that byte. Also: pulse rx low for 2 cycles only -> glitch rejected, no byte.
